// File: rtl/dm_arbiter_if.sv
// Request/acknowledge bundle for one data-memory requester.
// The requester holds req and its fields stable until it samples ack.
interface dm_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic        err;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input ack, err, rdata);
  modport slave  (input req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter that serialises CPU and debug accesses onto the
// single data-memory port and returns registered ack/err/rdata per requester.
module dm_arbiter #(
  parameter int unsigned DEPTH      = 256,
  parameter bit          RESET_PRIO = 1'b0
) (
  input  logic               clk_dm,
  input  logic               rst_n,
  dm_arbiter_if.slave        port_a,
  dm_arbiter_if.slave        port_b,
  output logic               Mem_Write,
  output logic [31:0]        DM_Addr,
  output logic [31:0]        M_W_Data,
  input  logic [31:0]        M_R_Data,
  output logic               busy
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic        sel_r, sel_s;
  logic        rr_last_r, rr_last_s;
  logic [1:0]  elig_s;
  logic        grant_valid_s, grant_s;
  logic        sel_we_s, in_range_s;
  logic [31:0] sel_addr_s, sel_wdata_s;
  logic [31:0] addr_hold_r, wdata_hold_r;
  logic        ack_a_r, ack_b_r, err_a_r, err_b_r;
  logic [31:0] rdata_a_r, rdata_b_r;

  // Fields of the currently granted port
  always_comb begin
    if (sel_r) begin
      sel_we_s    = port_b.we;
      sel_addr_s  = port_b.addr;
      sel_wdata_s = port_b.wdata;
    end else begin
      sel_we_s    = port_a.we;
      sel_addr_s  = port_a.addr;
      sel_wdata_s = port_a.wdata;
    end
    in_range_s = (sel_addr_s < DEPTH_W);
  end

  // Round-robin grant; in RESP the port being acked is not eligible
  always_comb begin
    elig_s = 2'b00;
    case (state_r)
      IDLE:    elig_s = {port_b.req, port_a.req};
      RESP:    elig_s = sel_r ? {1'b0, port_a.req} : {port_b.req, 1'b0};
      default: elig_s = 2'b00;
    endcase
    grant_valid_s = |elig_s;
    if (elig_s == 2'b11) begin
      grant_s = ~rr_last_r;
    end else begin
      grant_s = elig_s[1];
    end
  end

  // Next-state logic
  always_comb begin
    state_s   = state_r;
    sel_s     = sel_r;
    rr_last_s = rr_last_r;
    case (state_r)
      IDLE, RESP: begin
        if (grant_valid_s) begin
          state_s   = ACCESS;
          sel_s     = grant_s;
          rr_last_s = grant_s;
        end else begin
          state_s   = IDLE;
        end
      end
      ACCESS:  state_s = RESP;
      default: state_s = IDLE;
    endcase
  end

  // Memory port is live only in ACCESS and holds its last address/data otherwise
  always_comb begin
    if (state_r == ACCESS) begin
      Mem_Write = sel_we_s & in_range_s;
      DM_Addr   = sel_addr_s;
      M_W_Data  = sel_wdata_s;
    end else begin
      Mem_Write = 1'b0;
      DM_Addr   = addr_hold_r;
      M_W_Data  = wdata_hold_r;
    end
    busy = (state_r != IDLE);
  end

  // Control state registers
  always_ff @(posedge clk_dm or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      sel_r     <= 1'b0;
      rr_last_r <= ~RESET_PRIO;
    end else begin
      state_r   <= state_s;
      sel_r     <= sel_s;
      rr_last_r <= rr_last_s;
    end
  end

  // Captured response per port; out-of-range accesses return zero data
  always_ff @(posedge clk_dm or negedge rst_n) begin
    if (!rst_n) begin
      addr_hold_r  <= 32'd0;
      wdata_hold_r <= 32'd0;
      ack_a_r      <= 1'b0;
      ack_b_r      <= 1'b0;
      err_a_r      <= 1'b0;
      err_b_r      <= 1'b0;
      rdata_a_r    <= 32'd0;
      rdata_b_r    <= 32'd0;
    end else begin
      ack_a_r <= (state_r == ACCESS) && !sel_r;
      ack_b_r <= (state_r == ACCESS) && sel_r;
      if (state_r == ACCESS) begin
        addr_hold_r  <= sel_addr_s;
        wdata_hold_r <= sel_wdata_s;
        if (!sel_r) begin
          err_a_r <= ~in_range_s;
          if (!in_range_s) begin
            rdata_a_r <= 32'd0;
          end else if (!sel_we_s) begin
            rdata_a_r <= M_R_Data;
          end else begin
            rdata_a_r <= rdata_a_r;
          end
        end else begin
          err_b_r <= ~in_range_s;
          if (!in_range_s) begin
            rdata_b_r <= 32'd0;
          end else if (!sel_we_s) begin
            rdata_b_r <= M_R_Data;
          end else begin
            rdata_b_r <= rdata_b_r;
          end
        end
      end else begin
        addr_hold_r  <= addr_hold_r;
        wdata_hold_r <= wdata_hold_r;
      end
    end
  end

  assign port_a.ack   = ack_a_r;
  assign port_a.err   = err_a_r;
  assign port_a.rdata = rdata_a_r;
  assign port_b.ack   = ack_b_r;
  assign port_b.err   = err_b_r;
  assign port_b.rdata = rdata_b_r;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus randomized two-port
// traffic scored against a transaction-level memory model.
module tb_dm_arbiter;

  logic        clk_dm;
  logic        rst_n;
  logic        Mem_Write;
  logic [31:0] DM_Addr;
  logic [31:0] M_W_Data;
  logic [31:0] M_R_Data;
  logic        busy;

  dm_arbiter_if pa ();
  dm_arbiter_if pb ();

  dm_arbiter #(.DEPTH(256), .RESET_PRIO(1'b0)) dut (
    .clk_dm    (clk_dm),
    .rst_n     (rst_n),
    .port_a    (pa),
    .port_b    (pb),
    .Mem_Write (Mem_Write),
    .DM_Addr   (DM_Addr),
    .M_W_Data  (M_W_Data),
    .M_R_Data  (M_R_Data),
    .busy      (busy)
  );

  // Data memory: async read, write on posedge, initialised to index
  logic [31:0] mem [0:255];
  assign M_R_Data = mem[DM_Addr[7:0]];
  always @(posedge clk_dm) begin
    if (Mem_Write) mem[DM_Addr[7:0]] <= M_W_Data;
  end

  logic [31:0] ref_mem [0:255];
  logic [31:0] last_rdata [0:1];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int wr_cnt  = 0;
  int busy_cnt = 0;
  int b_ack_cnt = 0;
  logic [31:0] wr_addr = 32'd0;
  logic pend_v = 1'b0;
  logic pend_p = 1'b0;
  int last_ack_any = 0;

  initial clk_dm = 1'b0;
  always #5 clk_dm = ~clk_dm;

  always @(posedge clk_dm) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: write range, single ack per cycle, fairness and alternation spacing
  always @(negedge clk_dm) begin
    if (!rst_n) begin
      pend_v <= 1'b0;
    end else begin
      if (busy) busy_cnt <= busy_cnt + 1;
      if (pb.ack) b_ack_cnt <= b_ack_cnt + 1;
      if (Mem_Write) begin
        wr_cnt  <= wr_cnt + 1;
        wr_addr <= DM_Addr;
        chk("write_in_range", {31'd0, DM_Addr >= 32'd256}, 32'd0);
      end
      if (pa.ack && pb.ack) begin
        chk("dual_ack", 32'd1, 32'd0);
      end else if (pa.ack || pb.ack) begin
        if (pend_v) begin
          chk("rr_order", {31'd0, pb.ack}, {31'd0, pend_p});
          chk("rr_gap", cyc - last_ack_any, 32'd2);
        end
        pend_v       <= pb.ack ? pa.req : pb.req;
        pend_p       <= ~pb.ack;
        last_ack_any <= cyc;
      end
    end
  end

  task automatic do_txn(input int p, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output int ack_at);
    logic        got;
    logic        er;
    logic [31:0] rd;
    logic        exp_err;
    logic [31:0] exp_rd;
    got = 1'b0;
    er  = 1'b0;
    rd  = 32'd0;
    lat = 0;
    if (p == 0) begin
      pa.we = we; pa.addr = addr; pa.wdata = wdata; pa.req = 1'b1;
    end else begin
      pb.we = we; pb.addr = addr; pb.wdata = wdata; pb.req = 1'b1;
    end
    while (!got && lat <= 50) begin
      @(negedge clk_dm);
      if (p == 0) begin
        got = pa.ack; er = pa.err; rd = pa.rdata;
      end else begin
        got = pb.ack; er = pb.err; rd = pb.rdata;
      end
      if (!got) lat++;
    end
    ack_at = cyc;
    if (!got) begin
      chk(p == 0 ? "a_ack_timeout" : "b_ack_timeout", 32'd0, 32'd1);
    end else begin
      exp_err = (addr >= 32'd256);
      if (exp_err) exp_rd = 32'd0;
      else if (we) exp_rd = last_rdata[p];
      else exp_rd = ref_mem[addr[7:0]];
      if (!exp_err && we) ref_mem[addr[7:0]] = wdata;
      last_rdata[p] = exp_rd;
      chk(p == 0 ? "a_err" : "b_err", {31'd0, er}, {31'd0, exp_err});
      chk(p == 0 ? "a_rdata" : "b_rdata", rd, exp_rd);
    end
    @(posedge clk_dm);
    #1;
    if (p == 0) pa.req = 1'b0;
    else pb.req = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    pa.req = 1'b0;
    pb.req = 1'b0;
    repeat (2) @(posedge clk_dm);
    #1;
    rst_n = 1'b1;
    last_rdata[0] = 32'd0;
    last_rdata[1] = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    int lat, at, lat_a, lat_b, at_a, at_b, w0, b0, ba0;
    int at_s [0:3];
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'(i);
      ref_mem[i] = 32'(i);
    end
    last_rdata[0] = 32'd0;
    last_rdata[1] = 32'd0;
    pa.req = 1'b0; pa.we = 1'b0; pa.addr = 32'd0; pa.wdata = 32'd0;
    pb.req = 1'b0; pb.we = 1'b0; pb.addr = 32'd0; pb.wdata = 32'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_a_ack", {31'd0, pa.ack}, 32'd0);
    chk("rst_b_ack", {31'd0, pb.ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_write", {31'd0, Mem_Write}, 32'd0);
    chk("rst_dm_addr", DM_Addr, 32'd0);
    chk("rst_wdata", M_W_Data, 32'd0);
    chk("rst_a_rdata", pa.rdata, 32'd0);
    chk("rst_b_rdata", pb.rdata, 32'd0);
    apply_reset();

    // Single uncontended read
    b0 = busy_cnt; ba0 = b_ack_cnt;
    do_txn(0, 1'b0, 32'd5, 32'd0, lat, at);
    chk("read_latency", lat, 32'd2);
    chk("read_rdata", pa.rdata, 32'd5);
    chk("read_busy_cycles", busy_cnt - b0, 32'd2);
    chk("read_no_b_ack", b_ack_cnt - ba0, 32'd0);
    @(negedge clk_dm);
    chk("read_idle_after", {31'd0, busy}, 32'd0);
    @(posedge clk_dm); #1;

    // Write by B then read back by A
    w0 = wr_cnt;
    do_txn(1, 1'b1, 32'h10, 32'hDEADBEEF, lat, at);
    chk("wr_pulse_count", wr_cnt - w0, 32'd1);
    chk("wr_addr", wr_addr, 32'h10);
    do_txn(0, 1'b0, 32'h10, 32'd0, lat, at);
    chk("readback", pa.rdata, 32'hDEADBEEF);

    // Contended traffic from reset: A first, then strict alternation
    apply_reset();
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          do_txn(0, 1'b0, 32'(i), 32'd0, lat_a, at_a);
          if (i == 0) chk("contend_a_first_lat", lat_a, 32'd2);
        end
      end
      begin
        for (int j = 0; j < 4; j++) begin
          do_txn(1, 1'b1, 32'(32 + j), 32'hB000_0000 + 32'(j), lat_b, at_b);
          if (j == 0) chk("contend_b_first_lat", lat_b, 32'd4);
        end
      end
    join

    // Out-of-range write
    w0 = wr_cnt;
    do_txn(0, 1'b1, 32'd300, 32'hAAAA5555, lat, at);
    chk("oor_no_write", wr_cnt - w0, 32'd0);
    chk("oor_mem44", mem[44], 32'd44);

    // Reset during the ACCESS cycle of a write
    pa.we = 1'b1; pa.addr = 32'd20; pa.wdata = 32'h12345678; pa.req = 1'b1;
    @(posedge clk_dm); #2;
    chk("mid_access_write", {31'd0, Mem_Write}, 32'd1);
    chk("mid_access_addr", DM_Addr, 32'd20);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_write_drop", {31'd0, Mem_Write}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk_dm);
    chk("mid_rst_no_ack", {31'd0, pa.ack}, 32'd0);
    pa.req = 1'b0;
    @(posedge clk_dm); #1;
    rst_n = 1'b1;
    last_rdata[0] = 32'd0;
    last_rdata[1] = 32'd0;
    @(negedge clk_dm);
    chk("mid_rst_idle", {31'd0, busy}, 32'd0);
    chk("mid_rst_mem20", mem[20], ref_mem[20]);
    @(posedge clk_dm); #1;

    // Single-port streaming reads
    for (int i = 0; i < 4; i++) begin
      do_txn(0, 1'b0, 32'(i), 32'd0, lat, at_s[i]);
      chk("stream_rdata", pa.rdata, 32'(i));
      if (i > 0) chk("stream_gap", at_s[i] - at_s[i-1], 32'd3);
    end

    // Randomized traffic on both ports
    fork
      begin
        automatic int l0, t0, g0, r0;
        automatic logic [31:0] ad0;
        for (int i = 0; i < 60; i++) begin
          g0 = $urandom_range(0, 3);
          if (g0 > 0) begin
            repeat (g0) @(posedge clk_dm);
            #1;
          end
          r0 = $urandom_range(0, 9);
          if (r0 == 0) ad0 = 32'($urandom_range(256, 1023));
          else if (r0 == 1) ad0 = $urandom;
          else ad0 = 32'($urandom_range(0, 15));
          do_txn(0, 1'($urandom_range(0, 1)), ad0, $urandom, l0, t0);
        end
      end
      begin
        automatic int l1, t1, g1, r1;
        automatic logic [31:0] ad1;
        for (int j = 0; j < 60; j++) begin
          g1 = $urandom_range(0, 3);
          if (g1 > 0) begin
            repeat (g1) @(posedge clk_dm);
            #1;
          end
          r1 = $urandom_range(0, 9);
          if (r1 == 0) ad1 = 32'($urandom_range(256, 1023));
          else if (r1 == 1) ad1 = $urandom;
          else ad1 = 32'($urandom_range(0, 15));
          do_txn(1, 1'($urandom_range(0, 1)), ad1, $urandom, l1, t1);
        end
      end
    join

    begin
      automatic int diffs = 0;
      for (int k = 0; k < 256; k++) begin
        if (mem[k] !== ref_mem[k]) diffs++;
      end
      chk("final_mem_diffs", diffs, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
